// File: rtl/serial_ram_reader_pkg.sv
// Definitions shared by both ends of the nibble-serial RAM link, so the reader
// and the memory model agree on frame length, word widths and response latency.
package serial_ram_reader_pkg;

  localparam int unsigned DEF_ADDR_PINS   = 4;
  localparam int unsigned DEF_DATA_PINS   = 4;
  localparam int unsigned DEF_LOG2_CYCLES = 2;
  localparam int unsigned DEF_DELAY       = 2;

  function automatic int unsigned f_cycles(input int unsigned log2_cycles);
    return 32'd1 << log2_cycles;
  endfunction

  function automatic int unsigned f_word_bits(input int unsigned pins,
                                              input int unsigned log2_cycles);
    return pins * f_cycles(log2_cycles);
  endfunction

  // Address frame length, one address-register cycle, then the memory's output stages.
  function automatic int unsigned f_resp_latency(input int unsigned log2_cycles,
                                                 input int unsigned delay);
    return f_cycles(log2_cycles) + 1 + delay;
  endfunction

endpackage

// File: rtl/serial_ram_reader_shift_in.sv
// serial_shift_in: generic PINS-wide deserializer. Beats enter at the MS end so
// the first beat lands in the LSBs; the completed word is held until the next one.
module serial_shift_in
  import serial_ram_reader_pkg::*;
#(
  parameter int unsigned PINS  = DEF_DATA_PINS,
  parameter int unsigned BEATS = f_cycles(DEF_LOG2_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_shift,
  input  logic                  i_last,
  input  logic [PINS-1:0]       i_data,
  output logic [PINS*BEATS-1:0] o_word,
  output logic                  o_done
);

  localparam int unsigned W = PINS * BEATS;

  logic [W-1:0] r_sh;
  logic [W-1:0] r_word;
  logic         r_done;
  logic [W-1:0] w_next;

  assign w_next = W'({i_data, r_sh} >> PINS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh   <= '0;
      r_word <= '0;
      r_done <= 1'b0;
    end else if (i_en) begin
      r_done <= i_shift && i_last;
      if (i_shift) begin
        r_sh <= w_next;
        if (i_last) r_word <= w_next;
      end
    end
  end

  assign o_word = r_word;
  assign o_done = r_done;

endmodule

// File: rtl/serial_ram_reader.sv
// Initiator side of the nibble-serial RAM read link: one pipelined read per frame,
// address serialized LS nibble first, data deserialized RESP_LATENCY cycles later.
module serial_ram_reader
  import serial_ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_PINS    = DEF_ADDR_PINS,
  parameter int unsigned DATA_PINS    = DEF_DATA_PINS,
  parameter int unsigned LOG2_CYCLES  = DEF_LOG2_CYCLES,
  parameter int unsigned DELAY        = DEF_DELAY,
  parameter int unsigned RESP_LATENCY = f_resp_latency(LOG2_CYCLES, DELAY),
  localparam int unsigned CYCLES      = f_cycles(LOG2_CYCLES),
  localparam int unsigned ADDR_BITS   = f_word_bits(ADDR_PINS, LOG2_CYCLES),
  localparam int unsigned DATA_BITS   = f_word_bits(DATA_PINS, LOG2_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 req_valid,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 req_ready,
  output logic [ADDR_PINS-1:0] addr_out,
  input  logic [DATA_PINS-1:0] data_in,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data
);

  localparam int unsigned PIPE_LEN = RESP_LATENCY + CYCLES;

  logic [LOG2_CYCLES-1:0] r_phase;
  logic [ADDR_BITS-1:0]   r_addr_sh;
  logic [PIPE_LEN-1:0]    r_vpipe;

  logic w_last_phase;
  logic w_accept;
  logic w_sample;
  logic w_last_beat;

  assign w_last_phase = (r_phase == LOG2_CYCLES'(CYCLES - 1));
  assign req_ready    = en && w_last_phase;
  assign w_accept     = req_valid && req_ready;
  assign addr_out     = r_addr_sh[ADDR_PINS-1:0];

  // Bit 0 is set during a valid frame's phase-0 cycle; bit j marks j en-cycles later,
  // so the top CYCLES bits cover exactly that frame's returning data beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= LOG2_CYCLES'(2);
      r_addr_sh <= '0;
      r_vpipe   <= '0;
    end else if (en) begin
      r_phase <= r_phase + LOG2_CYCLES'(1);
      if (w_last_phase) r_addr_sh <= w_accept ? req_addr : '0;
      else              r_addr_sh <= r_addr_sh >> ADDR_PINS;
      r_vpipe <= {r_vpipe[PIPE_LEN-2:0], w_accept};
    end
  end

  assign w_sample    = |r_vpipe[PIPE_LEN-1:RESP_LATENCY];
  assign w_last_beat = r_vpipe[PIPE_LEN-1];

  serial_shift_in #(
    .PINS  (DATA_PINS),
    .BEATS (CYCLES)
  ) u_shift_in (
    .clk     (clk),
    .reset   (reset),
    .i_en    (en),
    .i_shift (w_sample),
    .i_last  (w_last_beat),
    .i_data  (data_in),
    .o_word  (rsp_data),
    .o_done  (rsp_valid)
  );

endmodule
